// File: rtl/traffic_analyzer_frame_capture_if.sv
// Bundle of the GMII receive tap and the register-block facing signals of the
// frame capture block. The master side is the surrounding analyzer, and the
// slave side is the capture block.
interface traffic_analyzer_frame_capture_if #(
    parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9
);
    logic [7:0]                           gmii_rxd;
    logic                                 gmii_rx_dv;
    logic                                 gmii_rx_er;
    logic                                 capture_en;
    logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0] frame_buf_address;
    logic [31:0]                          frame_buf_data;
    logic [31:0]                          frame_size_reg;
    logic [1:0]                           capture_state;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, capture_en, frame_buf_address,
        input  frame_buf_data, frame_size_reg, capture_state
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, capture_en, frame_buf_address,
        output frame_buf_data, frame_size_reg, capture_state
    );
endinterface

// File: rtl/traffic_analyzer_frame_capture.sv
// Single-shot GMII frame capture into a word-addressed snapshot RAM.
// Optional build macro FRAME_CAPTURE_PREAMBLE_EN: when it is defined, the
// preamble and SFD bytes are stored and counted ahead of the payload.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | disarmed, waiting for capture_en
// HUNT     | armed, waiting for an rx_dv=0 gap and then the start of a frame
// PREAMBLE | consuming 0x55 bytes, waiting for the 0xD5 SFD
// CAPTURE  | storing payload bytes; with done_q set, this state acts as DONE
module traffic_analyzer_frame_capture #(
    parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9
) (
    input  logic clk,
    input  logic resetn,
    traffic_analyzer_frame_capture_if.slave bus
);
    localparam int AW    = C_FRAME_BUF_ADDRESS_WIDTH;
    localparam int DEPTH = 1 << AW;

`ifdef FRAME_CAPTURE_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HUNT     = 2'd1,
        ST_PREAMBLE = 2'd2,
        ST_CAPTURE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        hunt_idle_q, hunt_idle_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        store_byte, frame_clr, end_frame, arm, pre_byte;

    logic [15:0] byte_cnt_q;
    logic [23:0] asm_q;
    logic        err_q, trunc_q;
    logic [31:0] frame_size_q;
    logic [31:0] rd_data_q;
    logic [31:0] mem_q [DEPTH];

    logic          in_range;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    // Bytes at or beyond the buffer capacity are counted but never written.
    assign in_range = ((32'(byte_cnt_q) >> (AW + 2)) == 32'd0);
    assign wr_addr  = byte_cnt_q[AW+1:2];
    assign wr_en    = in_range && ((store_byte && (byte_cnt_q[1:0] == 2'd3)) ||
                                   (end_frame && (byte_cnt_q[1:0] != 2'd0)));
    // Lanes above the last byte are already zero because the assembler is
    // cleared whenever a full word leaves it.
    assign wr_data  = store_byte ? {bus.gmii_rxd, asm_q} : {8'h00, asm_q};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            hunt_idle_q <= 1'b0;
            pre_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            hunt_idle_q <= hunt_idle_d;
            pre_cnt_q   <= pre_cnt_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        hunt_idle_d = hunt_idle_q;
        pre_cnt_d   = pre_cnt_q;
        store_byte  = 1'b0;
        frame_clr   = 1'b0;
        end_frame   = 1'b0;
        arm         = 1'b0;
        pre_byte    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.capture_en) begin
                    state_d     = ST_HUNT;
                    arm         = 1'b1;
                    frame_clr   = 1'b1;
                    done_d      = 1'b0;
                    hunt_idle_d = 1'b0;
                    pre_cnt_d   = 4'd0;
                end
            end
            ST_HUNT: begin
                if (!bus.capture_en)      state_d = ST_IDLE;
                else if (!bus.gmii_rx_dv) hunt_idle_d = 1'b1;
                else if (hunt_idle_q)     pre_byte = 1'b1;
            end
            ST_PREAMBLE: begin
                if (!bus.capture_en) begin
                    state_d = ST_IDLE;
                end else if (!bus.gmii_rx_dv) begin
                    state_d     = ST_HUNT;
                    hunt_idle_d = 1'b1;
                    pre_cnt_d   = 4'd0;
                    frame_clr   = 1'b1;
                end else begin
                    pre_byte = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!bus.capture_en) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (!done_q) begin
                    if (bus.gmii_rx_dv) begin
                        store_byte = 1'b1;
                    end else begin
                        end_frame = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The first byte after the idle gap gets the same check as the rest
        // of the preamble, so a frame that starts with garbage is rejected.
        if (pre_byte) begin
            if ((bus.gmii_rxd == 8'h55) && (pre_cnt_q < 4'd8)) begin
                state_d    = ST_PREAMBLE;
                pre_cnt_d  = pre_cnt_q + 4'd1;
                store_byte = PRE_EN;
            end else if (bus.gmii_rxd == 8'hD5) begin
                state_d    = ST_CAPTURE;
                pre_cnt_d  = 4'd0;
                store_byte = PRE_EN;
            end else begin
                state_d     = ST_HUNT;
                hunt_idle_d = 1'b0;
                pre_cnt_d   = 4'd0;
                frame_clr   = 1'b1;
            end
        end
    end

    // Byte counter, word assembler and frame flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_cnt_q <= 16'd0;
            asm_q      <= 24'd0;
            err_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else if (frame_clr) begin
            byte_cnt_q <= 16'd0;
            asm_q      <= 24'd0;
            err_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else if (store_byte) begin
            if (byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
            if (bus.gmii_rx_er)         err_q      <= 1'b1;
            if (!in_range)              trunc_q    <= 1'b1;
            if (byte_cnt_q[1:0] == 2'd3) asm_q <= 24'd0;
            else asm_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= bus.gmii_rxd;
        end
    end

    // Status word: cleared on arm, loaded once at end of frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        frame_size_q <= 32'd0;
        else if (arm)       frame_size_q <= 32'd0;
        else if (end_frame) frame_size_q <= {1'b1, trunc_q, err_q, 13'd0, byte_cnt_q};
    end

    // Snapshot RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Registered read port; a same-cycle write to the same word returns old data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_data_q <= 32'd0;
        else         rd_data_q <= mem_q[bus.frame_buf_address];
    end

    assign bus.frame_buf_data = rd_data_q;
    assign bus.frame_size_reg = frame_size_q;
    assign bus.capture_state  = state_q;
endmodule

// File: tb/tb_traffic_analyzer_frame_capture.sv
// Self-checking bench for traffic_analyzer_frame_capture, built with a
// 16-word (64-byte) buffer so that truncation is reachable with short frames.
module tb_traffic_analyzer_frame_capture;
    localparam int AW    = 4;
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [WORDS];

    traffic_analyzer_frame_capture_if #(.C_FRAME_BUF_ADDRESS_WIDTH(AW)) bus ();

    traffic_analyzer_frame_capture #(.C_FRAME_BUF_ADDRESS_WIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Expected buffer contents after a capture of len bytes of base+i.
    function automatic void model_frame(int len, int base, bit flush);
        logic [31:0] w;
        int n;
        w = 32'd0;
        n = (len > 4 * WORDS) ? 4 * WORDS : len;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) w = 32'd0;
            w[8 * (i % 4) +: 8] = 8'(base + i);
            if ((i % 4 == 3) || (flush && (i == n - 1))) ref_mem[i / 4] = w;
        end
    endfunction

    task automatic drive_idle(int n);
        repeat (n) begin
            @(negedge clk);
            bus.gmii_rx_dv = 1'b0;
            bus.gmii_rxd   = 8'h00;
            bus.gmii_rx_er = 1'b0;
        end
    endtask

    task automatic drive_byte(logic [7:0] d, logic er_b);
        @(negedge clk);
        bus.gmii_rx_dv = 1'b1;
        bus.gmii_rxd   = d;
        bus.gmii_rx_er = er_b;
    endtask

    task automatic drive_preamble();
        repeat (7) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
    endtask

    task automatic send_frame(int len, int base, int er_idx);
        drive_idle(2);
        drive_preamble();
        for (int i = 0; i < len; i++) drive_byte(8'(base + i), (i == er_idx));
        drive_idle(3);
    endtask

    task automatic rearm();
        @(negedge clk);
        bus.capture_en = 1'b0;
        @(negedge clk);
        bus.capture_en = 1'b1;
        @(negedge clk);
    endtask

    // Pipelined readout of the whole buffer against the reference image.
    task automatic read_all(string tag);
        logic [31:0] exp_q[$];
        int          addr_q[$];
        logic [31:0] e;
        int          a;
        for (int k = 0; k <= WORDS; k++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                checks++;
                if (bus.frame_buf_data !== e) begin
                    errors++;
                    $display("FAIL %s word %0d: got %h expected %h", tag, a, bus.frame_buf_data, e);
                end
            end
            if (k < WORDS) begin
                bus.frame_buf_address = k[AW-1:0];
                exp_q.push_back(ref_mem[k]);
                addr_q.push_back(k);
            end
        end
    endtask

    task automatic read_word(int addr, logic [31:0] value, string tag);
        logic [31:0] exp_q[$];
        logic [31:0] e;
        @(negedge clk);
        bus.frame_buf_address = addr[AW-1:0];
        exp_q.push_back(value);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.frame_buf_data !== e) begin
            errors++;
            $display("FAIL %s word %0d: got %h expected %h", tag, addr, bus.frame_buf_data, e);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.frame_size_reg !== 32'd0 || bus.frame_buf_data !== 32'd0 || bus.capture_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: size %h data %h state %0d expected 0/0/0",
                     bus.frame_size_reg, bus.frame_buf_data, bus.capture_state);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        @(negedge clk);
        bus.capture_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.capture_state !== 2'd1) begin
            errors++;
            $display("FAIL arm_state: got %0d expected 1", bus.capture_state);
        end
        send_frame(64, 0, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_0040) begin
            errors++;
            $display("FAIL full_size: got %h expected 80000040", bus.frame_size_reg);
        end
        checks++;
        if (bus.capture_state !== 2'd3) begin
            errors++;
            $display("FAIL done_state: got %0d expected 3", bus.capture_state);
        end
        model_frame(64, 0, 1'b1);
        read_word(0, 32'h0302_0100, "full_w0");
        read_word(15, 32'h3F3E_3D3C, "full_w15");
        read_all("full");
    endtask

    task automatic test_short_frame();
        @(negedge clk);
        bus.capture_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.capture_state !== 2'd0 || bus.frame_size_reg !== 32'h8000_0040) begin
            errors++;
            $display("FAIL disarm_retain: state %0d size %h expected 0/80000040",
                     bus.capture_state, bus.frame_size_reg);
        end
        bus.capture_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.frame_size_reg !== 32'd0) begin
            errors++;
            $display("FAIL arm_clear: got %h expected 0", bus.frame_size_reg);
        end
        send_frame(61, 0, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_003D) begin
            errors++;
            $display("FAIL short_size: got %h expected 8000003D", bus.frame_size_reg);
        end
        model_frame(61, 0, 1'b1);
        read_word(15, 32'h0000_003C, "short_w15");
        read_all("short");
    endtask

    task automatic test_truncate();
        rearm();
        send_frame(100, 0, -1);
        checks++;
        if (bus.frame_size_reg !== 32'hC000_0064) begin
            errors++;
            $display("FAIL trunc_size: got %h expected C0000064", bus.frame_size_reg);
        end
        model_frame(100, 0, 1'b1);
        read_all("trunc");
    endtask

    task automatic test_rx_error();
        rearm();
        send_frame(64, 0, 10);
        checks++;
        if (bus.frame_size_reg !== 32'hA000_0040) begin
            errors++;
            $display("FAIL rxer_size: got %h expected A0000040", bus.frame_size_reg);
        end
        model_frame(64, 0, 1'b1);
        read_all("rxer");
    endtask

    task automatic test_midframe_arm();
        @(negedge clk);
        bus.capture_en = 1'b0;
        drive_idle(2);
        drive_preamble();
        for (int i = 0; i < 4; i++) drive_byte(8'(8'h80 + i), 1'b0);
        bus.capture_en = 1'b1;
        for (int i = 4; i < 24; i++) drive_byte(8'(8'h80 + i), 1'b0);
        drive_idle(3);
        checks++;
        if (bus.capture_state !== 2'd1 || bus.frame_size_reg !== 32'd0) begin
            errors++;
            $display("FAIL midframe_ignore: state %0d size %h expected 1/0",
                     bus.capture_state, bus.frame_size_reg);
        end
        send_frame(20, 8'h20, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_0014) begin
            errors++;
            $display("FAIL midframe_next: got %h expected 80000014", bus.frame_size_reg);
        end
        model_frame(20, 8'h20, 1'b1);
        read_all("midframe");

        rearm();
        drive_idle(2);
        drive_byte(8'h55, 1'b0);
        drive_byte(8'h54, 1'b0);
        drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive_byte(8'(8'hA0 + i), 1'b0);
        drive_idle(3);
        checks++;
        if (bus.capture_state !== 2'd1 || bus.frame_size_reg !== 32'd0) begin
            errors++;
            $display("FAIL bad_preamble: state %0d size %h expected 1/0",
                     bus.capture_state, bus.frame_size_reg);
        end
        send_frame(9, 8'h40, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_0009) begin
            errors++;
            $display("FAIL after_bad_size: got %h expected 80000009", bus.frame_size_reg);
        end
        model_frame(9, 8'h40, 1'b1);
        read_all("after_bad");
    endtask

    task automatic test_done_hold();
        send_frame(30, 8'h90, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_0009 || bus.capture_state !== 2'd3) begin
            errors++;
            $display("FAIL done_hold: size %h state %0d expected 80000009/3",
                     bus.frame_size_reg, bus.capture_state);
        end
        read_all("done_hold");
        rearm();
        checks++;
        if (bus.frame_size_reg !== 32'd0 || bus.capture_state !== 2'd1) begin
            errors++;
            $display("FAIL rearm: size %h state %0d expected 0/1",
                     bus.frame_size_reg, bus.capture_state);
        end
        send_frame(12, 8'h11, -1);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_000C) begin
            errors++;
            $display("FAIL rearm_size: got %h expected 8000000C", bus.frame_size_reg);
        end
        model_frame(12, 8'h11, 1'b1);
        read_all("rearm");
    endtask

    task automatic test_disarm_capture();
        rearm();
        drive_idle(2);
        drive_preamble();
        for (int i = 0; i < 10; i++) drive_byte(8'(8'h60 + i), 1'b0);
        @(negedge clk);
        bus.capture_en = 1'b0;
        drive_idle(1);
        checks++;
        if (bus.capture_state !== 2'd0 || bus.frame_size_reg !== 32'd0) begin
            errors++;
            $display("FAIL disarm_capture: state %0d size %h expected 0/0",
                     bus.capture_state, bus.frame_size_reg);
        end
        model_frame(8, 8'h60, 1'b0);
        read_all("disarm");
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        bus.capture_en = 1'b1;
        drive_idle(2);
        drive_preamble();
        drive_idle(3);
        checks++;
        if (bus.frame_size_reg !== 32'h8000_0000 || bus.capture_state !== 2'd3) begin
            errors++;
            $display("FAIL zero_len: size %h state %0d expected 80000000/3",
                     bus.frame_size_reg, bus.capture_state);
        end
        read_all("zero_len");
    endtask

    task automatic test_reset_mid_capture();
        rearm();
        drive_idle(2);
        drive_preamble();
        for (int i = 0; i < 6; i++) drive_byte(8'(8'h70 + i), 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.frame_size_reg !== 32'd0 || bus.frame_buf_data !== 32'd0 || bus.capture_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: size %h data %h state %0d expected 0/0/0",
                     bus.frame_size_reg, bus.frame_buf_data, bus.capture_state);
        end
        bus.capture_en = 1'b0;
        drive_idle(1);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.capture_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: state %0d expected 0", bus.capture_state);
        end
        model_frame(4, 8'h70, 1'b0);
        read_all("reset_mid");
    endtask

    initial begin
        bus.gmii_rxd          = 8'h00;
        bus.gmii_rx_dv        = 1'b0;
        bus.gmii_rx_er        = 1'b0;
        bus.capture_en        = 1'b0;
        bus.frame_buf_address = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_truncate();
        test_rx_error();
        test_midframe_arm();
        test_done_hold();
        test_disarm_capture();
        test_zero_length();
        test_reset_mid_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_analyzer_frame_capture.md
Name: traffic_analyzer_frame_capture

Overview:
Captures one received GMII frame into a word-addressed snapshot buffer for CPU readout through the analyzer's register block. It sits beside the statistics path on the GMII receive tap, downstream of the PHY interface. It produces the frame_size and frame_buf_data values that the register block exposes. It also consumes frame_buf_address, which the register block auto-increments on each buffer read.

Parameters:
C_FRAME_BUF_ADDRESS_WIDTH, 9, word address width; buffer holds 2^AW 32-bit words (default 2048 bytes).

Ports:
clk  in  1  single clock, shared by the GMII receive path and the register block.
resetn  in  1  asynchronous, active-low reset.
gmii_rxd  in  8  receive data byte.
gmii_rx_dv  in  1  receive data valid.
gmii_rx_er  in  1  receive error.
capture_en  in  1  arm level, driven from a control register bit.
frame_buf_address  in  AW  buffer word read address.
frame_buf_data  out  32  buffer read data.
frame_size_reg  out  32  capture status and length.
capture_state  out  2  current FSM state, for debug.

Behaviour:
- Reset is asynchronous, active-low (resetn=0).
  - Reset values: FSM=IDLE; frame_size_reg=0; frame_buf_data=0; capture_state=0; internal counters 0.
  - Buffer RAM contents are not cleared.
- FSM states and encoding: IDLE=0, HUNT=1, PREAMBLE=2, CAPTURE=3, DONE=3 via a separate done flag. capture_state reports 3 for both CAPTURE and DONE.
- IDLE:
  - capture_en=1 -> HUNT.
  - On this transition, frame_size_reg clears to 0.
- HUNT:
  - Waits for a sample with rx_dv=0, so capture never joins a frame mid-stream.
  - The next rx_dv=1 sample -> PREAMBLE.
- PREAMBLE:
  - 0x55 bytes are consumed.
  - 0xD5 -> CAPTURE, starting with the next byte.
  - Any other byte, a 9th preamble byte, or rx_dv falling -> abort to HUNT. HUNT then waits for rx_dv=0 again.
- CAPTURE:
  - Each rx_dv=1 byte is placed in a word assembler, little-endian: byte n goes to lane n mod 4 (bits [8*(n%4)+7 : 8*(n%4)]).
  - The word is written to RAM at address n/4 when lane 3 fills.
  - Byte counter is 16 bits, saturating at 0xFFFF.
  - Bytes at or beyond 4*2^AW are not written; the truncated flag is set.
  - rx_er=1 on any byte sets the error flag; that byte is still stored.
- End of frame:
  - On the first rx_dv=0 sample in CAPTURE, a partial word is flushed with unused upper lanes zeroed.
  - frame_size_reg is loaded on that same cycle: [15:0] byte count; [29] rx_er seen; [30] truncated; [31] valid=1. Other bits are 0.
  - FSM -> DONE.
- DONE:
  - Holds the buffer and frame_size_reg unchanged while capture_en=1.
  - capture_en=0 -> IDLE; frame_size_reg is retained.
- capture_en=0 in HUNT, PREAMBLE or CAPTURE -> IDLE immediately; frame_size_reg stays 0 and any partial word is discarded.
- Re-arm requires capture_en to toggle 0 -> 1.
- RAM is simple dual-port, registered read: frame_buf_data = RAM[frame_buf_address], one cycle after the address is presented.
- A read and a write to the same word in the same cycle returns the old data.
- Reads are allowed in any state. Data is consistent only once frame_size_reg[31]=1.
- Address wrap: frame_buf_address is AW bits wide. Reads beyond the frame length return stale data from earlier frames.
- A zero-length frame (SFD immediately followed by rx_dv=0) gives frame_size_reg = 0x80000000, with no RAM write.

Optional Feature:
Macro FRAME_CAPTURE_PREAMBLE_EN.
- Defined: preamble bytes and the SFD are also stored and counted, starting at lane 0 of word 0. The frame payload follows directly after the SFD byte, and the abort rules are unchanged.
- Undefined: the buffer starts at the first byte after the SFD, as described above.

Test Plan:
1. Arm, send 7x0x55, 0xD5, then a 64-byte frame of bytes 0x00..0x3F -> frame_size_reg=0x80000040; word 0=0x03020100; word 15=0x3F3E3D3C.
2. Arm, send a 61-byte frame (bytes 0x00..0x3C) -> frame_size_reg=0x8000003D; word 15=0x0000003C.
3. AW=4 (64 bytes), send a 100-byte frame -> frame_size_reg=0xC0000064; words 0..15 hold bytes 0..63; RAM has no further writes.
4. Assert rx_er on byte 10 of a 64-byte frame -> frame_size_reg=0xA0000040.
5. Arm while rx_dv=1 mid-frame -> that frame is ignored and the next frame is captured. A bad preamble (0x55,0x54,...) -> no capture, then the next good frame is captured.
6. Capture a frame, keep capture_en=1 and send a second frame -> buffer and size unchanged. Toggle capture_en 0 -> 1 -> size reads 0 until the next frame, which is then captured. Pulse resetn low mid-CAPTURE -> all outputs 0 and state IDLE.
